// File: rtl/ppu_oam_scheduler.sv
// OAM port scheduler: one synchronous sprite-RAM port is shared by CPU OAMDATA
// writes, OAM DMA and the per-line sprite evaluator. Blocked writes wait in a queue.
module ppu_oam_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int START_COL  = 257,
    parameter int LAST_ROW   = 239
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] curr_row,
    input  logic [8:0] curr_col,
    input  logic       rendering_en,
    output logic       eval_start,
    input  logic       eval_busy,
    input  logic [7:0] eval_addr,
    output logic [7:0] eval_data,
    output logic [7:0] eval_base_addr,
    input  logic       cpu_addr_wr,
    input  logic       cpu_data_wr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_data_rd,
    output logic [7:0] cpu_rdata,
    input  logic       dma_wr,
    input  logic [7:0] dma_wdata,
    output logic [7:0] oam_addr,
    output logic [7:0] oam_wdata,
    output logic       oam_we,
    input  logic [7:0] oam_rdata,
    output logic       wr_dropped,
    output logic       eval_missed
);
    localparam int             PTR_W        = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] LP_DEPTH     = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [8:0]     LP_START_COL = 9'(START_COL);
    localparam logic [8:0]     LP_LAST_ROW  = 9'(LAST_ROW);

    typedef enum logic [1:0] {
        S_FREE  = 2'd0,
        S_WRITE = 2'd1,
        S_EVAL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wq_entry_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_oamaddr;
    logic [7:0]       r_cpu_rdata;
    logic             r_eval_start;
    logic             r_line_flag;
    logic             r_window_seen;
    logic             r_seen_busy;
    logic             r_refresh;
    logic             r_wr_dropped;
    logic             r_eval_missed;
    wq_entry_t        r_queue [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic       w_full;
    logic       w_empty;
    logic       w_wr_req;
    logic       w_push;
    logic       w_pop;
    logic       w_window;
    logic       w_launch;
    logic       w_idle_read;
    logic [7:0] w_wr_byte;
    logic [7:0] w_oam_addr;
    logic [7:0] w_oam_wdata;
    logic       w_oam_we;
    wq_entry_t  w_head;
    logic       w_unused;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == LP_DEPTH);
    assign w_pop     = (r_state == S_WRITE);
    assign w_wr_req  = dma_wr | cpu_data_wr;
    assign w_wr_byte = dma_wr ? dma_wdata : cpu_wdata;
    // A full queue still takes a write on the cycle its head is being popped.
    assign w_push    = w_wr_req && (!w_full || w_pop);
    assign w_head    = r_queue[r_rd_ptr];

    assign w_window = rendering_en && (curr_row <= LP_LAST_ROW) && (curr_col >= LP_START_COL);
    assign w_launch = w_window && !r_line_flag && (r_state == S_FREE) && !eval_busy;

    // NOTE: queue storage carries no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_queue[r_wr_ptr] <= {r_oamaddr, w_wr_byte};
        end
    end

    // NOTE: every register below uses <= so all of them sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_FREE;
            r_oamaddr     <= 8'h00;
            r_cpu_rdata   <= 8'h00;
            r_eval_start  <= 1'b0;
            r_line_flag   <= 1'b0;
            r_window_seen <= 1'b0;
            r_seen_busy   <= 1'b0;
            r_refresh     <= 1'b0;
            r_wr_dropped  <= 1'b0;
            r_eval_missed <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_state      <= w_next_state;
            r_eval_start <= w_launch;
            r_refresh    <= w_idle_read;

            if (r_refresh) begin
                r_cpu_rdata <= oam_rdata;
            end

            if (cpu_addr_wr) begin
                r_oamaddr <= cpu_wdata;
            end else if (w_push) begin
                r_oamaddr <= r_oamaddr + 8'd1;
            end

            if (w_wr_req && !w_push) begin
                r_wr_dropped <= 1'b1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_launch) begin
                r_line_flag <= 1'b1;
            end else if (curr_col == 9'd0) begin
                r_line_flag <= 1'b0;
            end

            // A line whose launch window opened but never launched is reported at wrap.
            if (curr_col == 9'd0) begin
                if (r_window_seen && !r_line_flag) begin
                    r_eval_missed <= 1'b1;
                end
                r_window_seen <= 1'b0;
            end else if (w_window) begin
                r_window_seen <= 1'b1;
            end

            if (r_state != S_EVAL) begin
                r_seen_busy <= 1'b0;
            end else if (r_seen_busy && !eval_busy) begin
                r_seen_busy <= 1'b0;
            end else if (eval_busy) begin
                r_seen_busy <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_oam_addr   = r_oamaddr;
        w_oam_wdata  = 8'h00;
        w_oam_we     = 1'b0;
        w_idle_read  = 1'b0;
        case (r_state)
            S_FREE: begin
                if (w_launch) begin
                    w_next_state = S_EVAL;
                end else if (!w_empty) begin
                    w_next_state = S_WRITE;
                end else begin
                    w_idle_read = 1'b1;
                end
            end
            S_WRITE: begin
                w_oam_addr   = w_head.addr;
                w_oam_wdata  = w_head.data;
                w_oam_we     = 1'b1;
                w_next_state = S_FREE;
            end
            S_EVAL: begin
                w_oam_addr = eval_addr;
                if (r_seen_busy && !eval_busy) begin
                    w_next_state = S_FREE;
                end
            end
            default: begin
                w_next_state = S_FREE;
            end
        endcase
    end

    assign oam_addr       = w_oam_addr;
    assign oam_wdata      = w_oam_wdata;
    assign oam_we         = w_oam_we;
    assign eval_start     = r_eval_start;
    assign eval_data      = oam_rdata;
    assign eval_base_addr = r_oamaddr;
    assign cpu_rdata      = (r_state == S_EVAL) ? 8'hFF : r_cpu_rdata;
    assign wr_dropped     = r_wr_dropped;
    assign eval_missed    = r_eval_missed;

    // OAMDATA reads are side-effect free; the strobe only marks when the CPU samples cpu_rdata.
    assign w_unused = cpu_data_rd;

endmodule
